mult32x32_arbiter: RTL and testbench
====================================

MULT32X32_ARBITER -- requirements
Module: mult32x32_arbiter

Interface
REQ-001 Parameter: NUM_REQ, 2, number of requesters sharing one multiplier (2..4).
REQ-002 Parameter: WDOG_CYCLES, 32, maximum cycles in BUSY before abort.
REQ-003 Port: clk  input  1  single clock, all logic on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: req_valid  input  NUM_REQ  per-requester request.
REQ-006 Port: req_a  input  NUM_REQ x 32  per-requester operand a.
REQ-007 Port: req_b  input  NUM_REQ x 32  per-requester operand b.
REQ-008 Port: req_ready  output  NUM_REQ  one-hot accept; transfer occurs when req_valid and req_ready are both high.
REQ-009 Port: resp_valid  output  NUM_REQ  one-cycle one-hot completion pulse.
REQ-010 Port: resp_product  output  64  product, valid while any resp_valid bit is high.
REQ-011 Port: resp_id  output  2  index of the requester served.
REQ-012 Port: wdog_err  output  1  sticky watchdog error flag.
REQ-013 Port: wdog_clr  input  1  synchronous clear of wdog_err.

Function
REQ-014 FSM states SHALL be IDLE, START, BUSY and RESP.
REQ-015 IDLE: the round-robin winner among asserted req_valid SHALL see req_ready high combinationally in the same cycle; other req_ready bits SHALL be low.
REQ-016 On accept, operands and winner id SHALL be latched and the FSM SHALL go to START; with no req_valid, the FSM SHALL stay in IDLE.
REQ-017 Round-robin: search SHALL start at (last_served+1) mod NUM_REQ; after reset requester 0 SHALL have highest priority.
REQ-018 START (exactly 1 cycle): mult start SHALL be high and latched operands SHALL be driven to the multiplier; next state SHALL be BUSY.
REQ-019 Operands to the multiplier SHALL stay stable from START until RESP.
REQ-020 BUSY: completion SHALL be busy low after busy has been seen high (seen_busy flag, cleared in START); next state SHALL be RESP with product latched.
REQ-021 Watchdog: a BUSY dwell of WDOG_CYCLES SHALL set wdog_err, force the FSM to IDLE without a response, and not update last_served.
REQ-022 RESP (1 cycle): resp_valid[id], resp_product and resp_id SHALL be driven; last_served SHALL become id; next state SHALL be IDLE.
REQ-023 Back-to-back operation: a new accept SHALL be possible in the first IDLE cycle after RESP, for minimum turnaround of 1 idle cycle.
REQ-024 req_valid deasserted by a non-granted requester SHALL have no effect; a granted request is never cancelled.
REQ-025 When a wdog_clr and watchdog set coincide, the set SHALL win.
REQ-026 req_ready SHALL be low in all states except IDLE.

Reset
REQ-027 Reset low SHALL asynchronously force: state IDLE, req_ready 0, resp_valid 0, resp_product 0, resp_id 0, wdog_err 0, last_served NUM_REQ-1, seen_busy 0.
REQ-028 The multiplier instance SHALL receive reset = NOT reset (active-high) so that both are reset together.
REQ-029 Reset mid-operation SHALL drop the transaction with no resp_valid, and the requester SHALL re-issue it.

Structure
REQ-030 Package mult_arb_pkg SHALL hold the state enum (IDLE, START, BUSY, RESP), the width constants (OP_W=32, PROD_W=64, ID_W=2) and the round-robin next-index function.
REQ-031 The block SHALL instantiate exactly one sub-module, mult32x32_fast, with ports clk, reset, start, a, b, busy and product.

Verification
REQ-032 Single request: req0 a=32'h0000_1234, b=32'h0000_0010 -> resp_valid[0] single pulse, product 64'h0000_0000_0001_2340, resp_id 0.
REQ-033 Full-width: req1 a=b=32'hFFFF_FFFF -> resp_valid[1], product 64'hFFFF_FFFE_0000_0001, and START-to-RESP no longer than WDOG_CYCLES.
REQ-034 Contention: req0 and req1 valid from reset with continuous traffic -> grants alternate 0,1,0,1 and each resp_id matches its grant.
REQ-035 Reset mid-BUSY: reset asserted 3 cycles after START -> no resp_valid, all outputs at reset values, next grant goes to req0.
REQ-036 Watchdog: multiplier busy forced high -> wdog_err set after 32 BUSY cycles, FSM returns to IDLE, wdog_clr clears the flag.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: shared FSM states, widths and round-robin pick for the multiplier arbiter
package mult_arb_pkg;
   typedef enum logic [1:0] {IDLE, START, BUSY, RESP} state_t;
   localparam int OP_W   = 32;
   localparam int PROD_W = 64;
   localparam int ID_W   = 2;
   // Returns {found, index}: first asserted valid bit searching from last+1, wrapping mod n.
   function automatic logic [ID_W:0] rr_next(input logic [3:0] valid, input logic [ID_W-1:0] last, input int n);
      logic [ID_W-1:0] idx;
      rr_next = '0;
      for (int i = 4; i >= 1; i--) begin
         idx = ID_W'((int'(last) + i) % n);
         if (i <= n && valid[idx]) rr_next = {1'b1, idx};
      end
   endfunction
endpackage

// File: rtl/mult32x32_fast.sv
// mult32x32_fast: sequential radix-16 unsigned multiplier, 8 busy cycles per start pulse
module mult32x32_fast
   import mult_arb_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [OP_W-1:0]   a,
   input  logic [OP_W-1:0]   b,
   output logic              busy,
   output logic [PROD_W-1:0] product
);
   logic [OP_W-1:0] ma, mb;
   logic [2:0]      cnt;
   // Load on start, then accumulate one 4-bit partial product of b per cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ma      <= '0;
         mb      <= '0;
         cnt     <= '0;
         busy    <= 1'b0;
         product <= '0;
      end else if (start) begin
         ma      <= a;
         mb      <= b;
         cnt     <= '0;
         busy    <= 1'b1;
         product <= '0;
      end else if (busy) begin
         product <= product + ((PROD_W'(ma) * PROD_W'(mb[3:0])) << {cnt, 2'b00});
         mb      <= mb >> 4;
         cnt     <= cnt + 1'b1;
         if (cnt == 3'd7) busy <= 1'b0;
      end
   end
endmodule

// File: rtl/mult32x32_arbiter.sv
// mult32x32_arbiter: round-robin sharing of one sequential 32x32 multiplier with busy watchdog
module mult32x32_arbiter
   import mult_arb_pkg::*;
#(
   parameter int NUM_REQ     = 2,
   parameter int WDOG_CYCLES = 32
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ-1:0][OP_W-1:0]   req_a,
   input  logic [NUM_REQ-1:0][OP_W-1:0]   req_b,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic [NUM_REQ-1:0]             resp_valid,
   output logic [PROD_W-1:0]              resp_product,
   output logic [ID_W-1:0]                resp_id,
   output logic                           wdog_err,
   input  logic                           wdog_clr
);
   localparam int WW = $clog2(WDOG_CYCLES) + 1;
   state_t            state;
   logic [ID_W-1:0]   last_served, id;
   logic [OP_W-1:0]   op_a, op_b, sel_a, sel_b;
   logic [ID_W:0]     pick;
   logic              seen_busy, busy, mult_rst, mult_start;
   logic [WW-1:0]     wcnt;
   logic [PROD_W-1:0] product;
   // Round-robin winner and its operands; ready is only offered in IDLE and never during reset.
   always_comb begin
      pick  = rr_next(4'(req_valid), last_served, NUM_REQ);
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (pick[ID_W-1:0] == ID_W'(i)) begin
            sel_a = req_a[i];
            sel_b = req_b[i];
         end
      req_ready = (reset && state == IDLE && pick[ID_W]) ? NUM_REQ'(1) << pick[ID_W-1:0] : '0;
   end
   assign mult_rst   = ~reset;
   assign mult_start = (state == START);
   mult32x32_fast u_mult (
      .clk     (clk),
      .reset   (mult_rst),
      .start   (mult_start),
      .a       (op_a),
      .b       (op_b),
      .busy    (busy),
      .product (product)
   );
   // Transaction FSM; the watchdog set is written after the clear so it wins on a tie.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         resp_valid   <= '0;
         resp_product <= '0;
         resp_id      <= '0;
         wdog_err     <= 1'b0;
         last_served  <= ID_W'(NUM_REQ - 1);
         seen_busy    <= 1'b0;
         id           <= '0;
         op_a         <= '0;
         op_b         <= '0;
         wcnt         <= '0;
      end else begin
         resp_valid <= '0;
         if (wdog_clr) wdog_err <= 1'b0;
         case (state)
            IDLE: if (pick[ID_W]) begin
               op_a  <= sel_a;
               op_b  <= sel_b;
               id    <= pick[ID_W-1:0];
               state <= START;
            end
            START: begin
               seen_busy <= 1'b0;
               wcnt      <= '0;
               state     <= BUSY;
            end
            BUSY: begin
               if (busy) seen_busy <= 1'b1;
               if (seen_busy && !busy) begin
                  resp_product <= product;
                  resp_id      <= id;
                  resp_valid   <= NUM_REQ'(1) << id;
                  last_served  <= id;
                  state        <= RESP;
               end else if (wcnt == WW'(WDOG_CYCLES - 1)) begin
                  wdog_err <= 1'b1;
                  state    <= IDLE;
               end else begin
                  wcnt <= wcnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mult32x32_arbiter.sv
// tb_mult32x32_arbiter: directed checks of arbitration, products, reset abort and watchdog
module tb_mult32x32_arbiter;
   logic             clk = 1'b0, reset = 1'b0, wdog_clr = 1'b0, wd_clr = 1'b0;
   logic [1:0]       req_valid = '0, wd_valid = '0;
   logic [1:0][31:0] req_a, req_b;
   logic [1:0]       req_ready, resp_valid, wd_ready, wd_rv;
   logic [63:0]      resp_product, wd_prod;
   logic [1:0]       resp_id, wd_id;
   logic             wdog_err, wd_err;
   int               vecs = 0, errs = 0, n = 0;
   logic             seen;

   mult32x32_arbiter #(.NUM_REQ(2), .WDOG_CYCLES(32)) u_dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready), .resp_valid(resp_valid), .resp_product(resp_product),
      .resp_id(resp_id), .wdog_err(wdog_err), .wdog_clr(wdog_clr));

   // Short watchdog so the sequential multiplier always overruns it.
   mult32x32_arbiter #(.NUM_REQ(2), .WDOG_CYCLES(4)) u_wd (
      .clk(clk), .reset(reset), .req_valid(wd_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(wd_ready), .resp_valid(wd_rv), .resp_product(wd_prod),
      .resp_id(wd_id), .wdog_err(wd_err), .wdog_clr(wd_clr));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_resp(output int cnt);
      cnt = 0;
      while (cnt < 40) begin
         step();
         cnt++;
         if (resp_valid != 0) break;
      end
   endtask

   task automatic wait_wd(output int cnt);
      cnt = 0;
      seen = 1'b0;
      while (cnt < 40) begin
         step();
         cnt++;
         if (wd_rv != 0) seen = 1'b1;
         if (wd_err) break;
      end
   endtask

   initial begin
      req_a = '0;
      req_b = '0;
      step();
      step();
      chk("rst_ready", 64'(req_ready), 64'd0);
      chk("rst_rvalid", 64'(resp_valid), 64'd0);
      chk("rst_product", resp_product, 64'd0);
      chk("rst_id", 64'(resp_id), 64'd0);
      chk("rst_wdog", 64'(wdog_err), 64'd0);
      reset = 1'b1;

      req_a[0] = 32'h0000_1234;
      req_b[0] = 32'h0000_0010;
      req_valid = 2'b01;
      #1;
      chk("single_ready", 64'(req_ready), 64'h1);
      step();
      req_valid = 2'b11;
      #1;
      chk("start_ready_low", 64'(req_ready), 64'h0);
      req_valid = 2'b00;
      wait_resp(n);
      chk("single_rvalid", 64'(resp_valid), 64'h1);
      chk("single_product", resp_product, 64'h0000_0000_0001_2340);
      chk("single_id", 64'(resp_id), 64'd0);
      chk("single_wdog", 64'(wdog_err), 64'd0);
      step();
      chk("single_pulse", 64'(resp_valid), 64'h0);

      req_a[1] = 32'hFFFF_FFFF;
      req_b[1] = 32'hFFFF_FFFF;
      req_valid = 2'b10;
      #1;
      chk("full_ready", 64'(req_ready), 64'h2);
      step();
      req_valid = 2'b00;
      wait_resp(n);
      chk("full_rvalid", 64'(resp_valid), 64'h2);
      chk("full_product", resp_product, 64'hFFFF_FFFE_0000_0001);
      chk("full_id", 64'(resp_id), 64'd1);
      chk("full_latency_le_wdog", 64'(n <= 32), 64'd1);
      step();

      reset = 1'b0;
      step();
      reset = 1'b1;
      req_a[0] = 32'd3;
      req_b[0] = 32'd5;
      req_a[1] = 32'd7;
      req_b[1] = 32'd9;
      req_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("rr_ready", 64'(req_ready), (k % 2) ? 64'h2 : 64'h1);
         step();
         wait_resp(n);
         chk("rr_rvalid", 64'(resp_valid), (k % 2) ? 64'h2 : 64'h1);
         chk("rr_id", 64'(resp_id), 64'(k % 2));
         chk("rr_product", resp_product, (k % 2) ? 64'd63 : 64'd15);
         step();
      end
      req_valid = 2'b00;

      req_a[0] = 32'h55;
      req_b[0] = 32'h2;
      req_valid = 2'b01;
      step();
      req_valid = 2'b00;
      step();
      step();
      step();
      req_valid = 2'b11;
      reset = 1'b0;
      #1;
      chk("midrst_ready", 64'(req_ready), 64'h0);
      chk("midrst_rvalid", 64'(resp_valid), 64'h0);
      chk("midrst_product", resp_product, 64'd0);
      chk("midrst_id", 64'(resp_id), 64'd0);
      chk("midrst_wdog", 64'(wdog_err), 64'd0);
      req_valid = 2'b00;
      step();
      step();
      reset = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 15; k++) begin
         step();
         if (resp_valid != 0) seen = 1'b1;
      end
      chk("midrst_no_resp", 64'(seen), 64'd0);
      req_valid = 2'b11;
      #1;
      chk("midrst_next_grant", 64'(req_ready), 64'h1);
      req_valid = 2'b00;

      wd_valid = 2'b01;
      #1;
      chk("wd_ready", 64'(wd_ready), 64'h1);
      step();
      wd_valid = 2'b00;
      wait_wd(n);
      chk("wd_err_set", 64'(wd_err), 64'd1);
      chk("wd_dwell", 64'(n), 64'd5);
      chk("wd_no_resp", 64'(seen), 64'd0);
      wd_valid = 2'b11;
      #1;
      chk("wd_idle_last_kept", 64'(wd_ready), 64'h1);
      wd_valid = 2'b00;
      wd_clr = 1'b1;
      step();
      wd_clr = 1'b0;
      chk("wd_clr", 64'(wd_err), 64'd0);

      wd_valid = 2'b01;
      step();
      wd_valid = 2'b00;
      wd_clr = 1'b1;
      wait_wd(n);
      chk("wd_set_wins", 64'(wd_err), 64'd1);
      step();
      wd_clr = 1'b0;
      chk("wd_clr_after", 64'(wd_err), 64'd0);
      chk("main_wdog_quiet", 64'(wdog_err), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
